// File: rtl/tdm_pkg.sv
// Shared constants, state encoding and frame-length helper for the TDM receive path.
package tdm_pkg;

  localparam int NUM_CH = 4;
  localparam int SLOT_W = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    PAR  = 2'd2
  } state_t;

  // Enabled cycles per frame: WIDTH data rounds plus an optional parity round.
  function automatic int frame_len(input int width, input bit parity);
    return NUM_CH * (width + (parity ? 1 : 0));
  endfunction

endpackage

// File: rtl/tdm_chan_shreg.sv
// One channel of the TDM receiver: MSB-first shift register plus the word
// handed to the consumer when a frame completes.
module tdm_chan_shreg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             capture,
  input  logic             d,
  output logic [WIDTH-1:0] q,
  output logic             word_par
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] sr_next;

  // A clear with a simultaneous shift leaves only the new bit, so a restart
  // can sample the channel 0 MSB on the same edge.
  always_comb begin
    sr_next = clear ? '0 : sr;
    if (shift) begin
      sr_next = {sr_next[WIDTH-2:0], d};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr <= '0;
      q  <= '0;
    end else begin
      sr <= sr_next;
      if (capture) begin
        q <= sr_next;
      end
    end
  end

  assign word_par = ^sr;

endmodule

// File: rtl/tdm_demux4.sv
// Receive side of the 4-channel TDM serial link: slot rotation, frame FSM and
// per-channel word reassembly. Define TDM_DEMUX_PARITY_EN for the parity round.
module tdm_demux4 #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             sync,
  input  logic             d,
  output logic             s1,
  output logic             s0,
  output logic [WIDTH-1:0] q0,
  output logic [WIDTH-1:0] q1,
  output logic [WIDTH-1:0] q2,
  output logic [WIDTH-1:0] q3,
  output logic             vld,
  output logic [3:0]       perr
);

  import tdm_pkg::*;

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0]  LAST_BIT  = CNT_W'(WIDTH - 1);

  state_t               state;
  state_t               state_next;
  logic [SLOT_W-1:0]    slot;
  logic [CNT_W-1:0]     bitcnt;
  logic                 start;
  logic                 last_data;
  logic                 frame_done;
  logic                 clear_all;
  logic [NUM_CH-1:0]    shift_en;
  logic [NUM_CH-1:0]    word_par;
  logic                 vld_r;
  logic [WIDTH-1:0]     q_arr [NUM_CH];

  // sync with en restarts the frame from any state, including mid-frame.
  assign start     = en & sync;
  assign last_data = (state == RECV) && (slot == LAST_SLOT) && (bitcnt == LAST_BIT);

`ifdef TDM_DEMUX_PARITY_EN
  logic last_par;
  assign last_par = (state == PAR) && (slot == LAST_SLOT);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    if (start) begin
      state_next = RECV;
    end else if (en) begin
`ifdef TDM_DEMUX_PARITY_EN
      if (last_data) begin
        state_next = PAR;
      end else if (last_par) begin
        state_next = RECV;
      end
`endif
    end
  end

  always_comb begin
    clear_all = start;
    shift_en  = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (en) begin
        if (start) begin
          shift_en[k] = (k == 0);
        end else if ((state == RECV) && (slot == SLOT_W'(k))) begin
          shift_en[k] = 1'b1;
        end
      end
    end
`ifdef TDM_DEMUX_PARITY_EN
    frame_done = en & ~sync & last_par;
`else
    frame_done = en & ~sync & last_data;
`endif
  end

  // The restart edge consumes slot 0, so the counter resumes at slot 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot   <= '0;
      bitcnt <= '0;
    end else if (start) begin
      slot   <= SLOT_W'(1);
      bitcnt <= '0;
    end else if (en && (state != IDLE)) begin
      slot <= slot + SLOT_W'(1);
      if ((state == RECV) && (slot == LAST_SLOT)) begin
        bitcnt <= (bitcnt == LAST_BIT) ? '0 : bitcnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_r <= 1'b0;
    end else begin
      vld_r <= frame_done;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_chan
    tdm_chan_shreg #(
      .WIDTH(WIDTH)
    ) u_shreg (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear_all),
      .shift   (shift_en[k]),
      .capture (frame_done),
      .d       (d),
      .q       (q_arr[k]),
      .word_par(word_par[k])
    );
  end

`ifdef TDM_DEMUX_PARITY_EN
  // Slot 3's parity bit arrives on the completing edge, so it is taken from d.
  logic [NUM_CH-2:0] par_bits;
  logic [NUM_CH-1:0] perr_r;

  always_ff @(posedge clk) begin
    if (rst) begin
      par_bits <= '0;
      perr_r   <= '0;
    end else begin
      if (en && !sync && (state == PAR) && (slot != LAST_SLOT)) begin
        par_bits[slot] <= d;
      end
      if (frame_done) begin
        perr_r <= word_par ^ {d, par_bits};
      end
    end
  end

  assign perr = perr_r;
`else
  logic unused_par;
  assign unused_par = ^word_par;
  assign perr       = '0;
`endif

  assign {s1, s0} = slot;
  assign vld      = vld_r;
  assign q0       = q_arr[0];
  assign q1       = q_arr[1];
  assign q2       = q_arr[2];
  assign q3       = q_arr[3];

endmodule

// File: tb/tb_tdm_demux4.sv
// Self-checking bench for tdm_demux4 (WIDTH=4); also covers TDM_DEMUX_PARITY_EN builds.
module tb_tdm_demux4;

  localparam int WIDTH = 4;
  localparam int ND    = 4 * WIDTH;
`ifdef TDM_DEMUX_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NB = ND + (PAR_EN ? 4 : 0);

  logic             clk;
  logic             rst;
  logic             en;
  logic             sync;
  logic             d;
  logic             s1;
  logic             s0;
  logic [WIDTH-1:0] q0;
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;
  logic [WIDTH-1:0] q3;
  logic             vld;
  logic [3:0]       perr;

  typedef struct {
    logic [15:0] stream;
    logic [3:0]  par;
    logic [3:0]  exp_q0;
    logic [3:0]  exp_q1;
    logic [3:0]  exp_q2;
    logic [3:0]  exp_q3;
    logic [3:0]  exp_perr;
  } vec_t;

  typedef struct {
    logic [3:0] q0;
    logic [3:0] q1;
    logic [3:0] q2;
    logic [3:0] q3;
    logic [3:0] perr;
  } exp_t;

  vec_t vecs [4];
  exp_t sb [$];
  int   vld_cycles [$];
  int   checks;
  int   errors;
  int   cyc;

  tdm_demux4 #(
    .WIDTH(WIDTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .sync(sync),
    .d   (d),
    .s1  (s1),
    .s0  (s0),
    .q0  (q0),
    .q1  (q1),
    .q2  (q2),
    .q3  (q3),
    .vld (vld),
    .perr(perr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic s, input logic b);
    @(negedge clk);
    en   = e;
    sync = s;
    d    = b;
  endtask

  // Drives one frame of vecs[idx]; cut_at stops before that sample, stall_at
  // inserts stall_len disabled cycles before that sample.
  task automatic sendStream(input int idx, input logic do_sync, input int stall_at,
                            input int stall_len, input int cut_at, input logic expect_out);
    vec_t v;
    exp_t e;
    logic b;
    v = vecs[idx];
    for (int i = 0; i < NB; i++) begin
      if (i == cut_at) return;
      if (i == stall_at) begin
        for (int s = 0; s < stall_len; s++) begin
          applyStimulus(1'b0, 1'b0, 1'b0);
          @(posedge clk);
          #1;
          checkOutput("stall_slot", {30'd0, s1, s0}, i % 4);
          checkOutput("stall_vld", {31'd0, vld}, 0);
        end
      end
      if (i < ND) b = v.stream[4'(ND - 1 - i)];
      else        b = v.par[2'(i - ND)];
      if ((i == NB - 1) && expect_out) begin
        e.q0   = v.exp_q0;
        e.q1   = v.exp_q1;
        e.q2   = v.exp_q2;
        e.q3   = v.exp_q3;
        e.perr = PAR_EN ? v.exp_perr : 4'h0;
        sb.push_back(e);
      end
      applyStimulus(1'b1, do_sync && (i == 0), b);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (vld === 1'b1) begin
      vld_cycles.push_back(cyc);
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_vld: got vld=1 at cycle %0d, expected no pulse", cyc);
      end else begin
        e = sb.pop_front();
        checkOutput("q0", {28'd0, q0}, {28'd0, e.q0});
        checkOutput("q1", {28'd0, q1}, {28'd0, e.q1});
        checkOutput("q2", {28'd0, q2}, {28'd0, e.q2});
        checkOutput("q3", {28'd0, q3}, {28'd0, e.q3});
        checkOutput("perr", {28'd0, perr}, {28'd0, e.perr});
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    // Serial streams (MSB first, slot-interleaved) with hand-decoded words.
    vecs[0] = '{16'b1010_0110_1010_0110, 4'b0100, 4'hA, 4'h5, 4'hF, 4'h0, 4'b0100};
    vecs[1] = '{16'b0101_0100_1000_1010, 4'b1100, 4'h3, 4'hC, 4'h1, 4'h8, 4'b0000};
    vecs[2] = '{16'b1010_0111_0111_1001, 4'b0000, 4'h9, 4'h6, 4'hE, 4'h7, 4'b1100};
    vecs[3] = '{16'b1001_1010_1001_1010, 4'b0001, 4'hF, 4'h0, 4'h5, 4'hA, 4'b0001};

    checks = 0;
    errors = 0;
    rst  = 1'b1;
    en   = 1'b0;
    sync = 1'b0;
    d    = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_slot", {30'd0, s1, s0}, 0);
    checkOutput("reset_q0", {28'd0, q0}, 0);
    checkOutput("reset_q1", {28'd0, q1}, 0);
    checkOutput("reset_q2", {28'd0, q2}, 0);
    checkOutput("reset_q3", {28'd0, q3}, 0);
    checkOutput("reset_vld", {31'd0, vld}, 0);
    checkOutput("reset_perr", {28'd0, perr}, 0);
    rst = 1'b0;

    // Back-to-back frames: sync only on the first one.
    vld_cycles.delete();
    for (int n = 0; n < 4; n++) sendStream(n, n == 0, -1, 0, -1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("b2b_count", vld_cycles.size(), 4);
    for (int i = 1; i < vld_cycles.size(); i++)
      checkOutput("b2b_spacing", vld_cycles[i] - vld_cycles[i-1], NB);
    checkOutput("q_hold", {28'd0, q0}, 32'hF);

    // Stall of 5 cycles after 6 samples.
    sendStream(0, 1'b1, 6, 5, -1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Resync at enabled sample 9 discards the partial frame.
    sendStream(2, 1'b1, -1, 0, 8, 1'b0);
    sendStream(1, 1'b1, -1, 0, -1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);

    // Sync on what would be the final sampling edge wins over completion.
    sendStream(3, 1'b1, -1, 0, NB - 1, 1'b0);
    sendStream(2, 1'b1, -1, 0, -1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("sb_drained", sb.size(), 0);

    // Reset after 7 samples; a following frame without sync must be ignored.
    sendStream(0, 1'b1, -1, 0, 7, 1'b0);
    @(negedge clk);
    en  = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_slot", {30'd0, s1, s0}, 0);
    checkOutput("midrst_q0", {28'd0, q0}, 0);
    checkOutput("midrst_q1", {28'd0, q1}, 0);
    checkOutput("midrst_q2", {28'd0, q2}, 0);
    checkOutput("midrst_q3", {28'd0, q3}, 0);
    checkOutput("midrst_vld", {31'd0, vld}, 0);
    sendStream(1, 1'b0, -1, 0, -1, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("nosync_slot", {30'd0, s1, s0}, 0);
    checkOutput("nosync_q0", {28'd0, q0}, 0);
    checkOutput("nosync_q1", {28'd0, q1}, 0);
    checkOutput("final_sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
